// File: rtl/gf2_div_pkg.sv
// Shared sizes and FSM state type for the bit-serial GF(2) polynomial divider.
package gf2_div_pkg;

  localparam int unsigned DW    = 512;
  localparam int unsigned VW    = 256;
  localparam int unsigned CNT_W = $clog2(DW);
  localparam int unsigned DEG_W = $clog2(VW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    FIN
  } state_t;

endpackage

// File: rtl/gf2_poly_divider_if.sv
// Request/result bundle between a requester and the GF(2) polynomial divider.
interface gf2_poly_divider_if;
  import gf2_div_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, err, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, err, quotient, remainder
  );

endinterface

// File: rtl/gf2_msb_degree.sv
// Priority encoder: index of the highest set bit of a VW-bit polynomial plus a zero flag.
module gf2_msb_degree
  import gf2_div_pkg::*;
(
  input  logic [VW-1:0]    vec,
  output logic [DEG_W-1:0] deg,
  output logic             zero
);

  always_comb begin
    deg = '0;
    for (int unsigned i = 0; i < VW; i++) begin
      if (vec[i]) begin
        deg = DEG_W'(i);
      end
    end
    zero = ~|vec;
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2) long divider: one dividend bit per cycle, MSB first, XOR-only reduction.
module gf2_poly_divider
  import gf2_div_pkg::*;
(
  input logic               clk,
  input logic               rst,
  gf2_poly_divider_if.slave bus
);

  state_t           state;
  logic [DW-1:0]    s;
  logic [DW-1:0]    q;
  logic [VW-1:0]    r;
  logic [VW-1:0]    v;
  logic [DEG_W-1:0] n;
  logic [CNT_W-1:0] cnt;

  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [DW-1:0]    quot_q;
  logic [VW-1:0]    rem_q;

  logic [DEG_W-1:0] msb_deg;
  logic             v_zero;
  logic [VW:0]      t;
  logic             qbit;
  logic [VW-1:0]    r_next;
  logic [DW-1:0]    q_next;

  gf2_msb_degree u_msb_degree (
    .vec  (v),
    .deg  (msb_deg),
    .zero (v_zero)
  );

  // r always has degree below n, so bringing in one bit can only raise it to n.
  always_comb begin
    t      = {r, s[DW-1]};
    qbit   = t[{1'b0, n}];
    r_next = t[VW-1:0] ^ (qbit ? v : '0);
    q_next = {q[DW-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      s      <= '0;
      q      <= '0;
      r      <= '0;
      v      <= '0;
      n      <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            s      <= bus.dividend;
            v      <= bus.divisor;
            r      <= '0;
            q      <= '0;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (v_zero) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            quot_q <= '0;
            rem_q  <= '0;
            state  <= FIN;
          end else begin
            n     <= msb_deg;
            cnt   <= CNT_W'(DW - 1);
            state <= DIV;
          end
        end
        DIV: begin
          r <= r_next;
          q <= q_next;
          s <= {s[DW-2:0], 1'b0};
          if (cnt == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b0;
            quot_q <= q_next;
            rem_q  <= r_next;
            state  <= FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and round-trip checks of the GF(2) polynomial divider.
module tb_gf2_poly_divider;
  import gf2_div_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  gf2_poly_divider_if bus ();

  gf2_poly_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  function automatic logic [511:0] clmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) if (b[i]) c = c ^ ({256'b0, a} << i);
    return c;
  endfunction

  function automatic int deg256(input logic [255:0] b);
    int d;
    d = 0;
    for (int i = 0; i < 256; i++) if (b[i]) d = i;
    return d;
  endfunction

  // Launch one division; cycle 1 is the cycle after start is sampled.
  task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] qo, output logic [VW-1:0] ro,
                         output logic eo, output int cyc, output logic busy1,
                         output logic busy_done);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc   = 1;
    busy1 = bus.busy;
    while (bus.done !== 1'b1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    qo        = bus.quotient;
    ro        = bus.remainder;
    eo        = bus.err;
    busy_done = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.quotient !== '0 ||
        bus.remainder !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy/done/err=%b%b%b q=%h r=%h required all zero",
               bus.busy, bus.done, bus.err, bus.quotient, bus.remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_small();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic e, b1, bd;
    int c;
    run_div(512'h9, 256'h3, q, r, e, c, b1, bd);
    n_vec++;
    if (q !== 512'h7 || r !== 256'h0 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL div_9_3: q=%h r=%h err=%b required q=7 r=0 err=0", q, r, e);
    end
    n_vec++;
    if (c !== 514) begin
      n_bad++;
      $display("FAIL latency_9_3: done at cycle %0d required 514", c);
    end
    n_vec++;
    if (b1 !== 1'b1 || bd !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_9_3: busy at cycle1=%b at done=%b required 1 and 0", b1, bd);
    end
    run_div(512'hB, 256'h3, q, r, e, c, b1, bd);
    n_vec++;
    if (q !== 512'h6 || r !== 256'h1 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL div_B_3: q=%h r=%h err=%b required q=6 r=1 err=0", q, r, e);
    end
    run_div(512'h5, 256'h10, q, r, e, c, b1, bd);
    n_vec++;
    if (q !== 512'h0 || r !== 256'h5) begin
      n_bad++;
      $display("FAIL low_degree_dividend: q=%h r=%h required q=0 r=5", q, r);
    end
  endtask

  task automatic test_top_bits();
    logic [DW-1:0] q, a;
    logic [VW-1:0] r, b;
    logic e, b1, bd;
    int c;
    a = '0; a[511] = 1'b1;
    b = '0; b[255] = 1'b1;
    run_div(a, b, q, r, e, c, b1, bd);
    n_vec++;
    if (q !== (512'h1 << 256) || r !== '0) begin
      n_bad++;
      $display("FAIL top_bits: q=%h r=%h required q=1<<256 r=0", q, r);
    end
  endtask

  task automatic test_zero_divisor();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic e, b1, bd;
    int c;
    run_div(512'h1234_5678, 256'h0, q, r, e, c, b1, bd);
    n_vec++;
    if (c !== 2 || e !== 1'b1 || q !== '0 || r !== '0) begin
      n_bad++;
      $display("FAIL zero_divisor: cycle=%0d err=%b q=%h r=%h required 2,1,0,0", c, e, q, r);
    end
    run_div(512'hDEAD, 256'h1, q, r, e, c, b1, bd);
    n_vec++;
    if (q !== 512'hDEAD || r !== '0 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL unit_divisor: q=%h r=%h err=%b required q=dead r=0 err=0", q, r, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic e, b1, bd;
    int c;
    // run_div drives start on the first cycle after the previous done.
    run_div(512'hB, 256'h3, q, r, e, c, b1, bd);
    run_div(512'h9, 256'h3, q, r, e, c, b1, bd);
    n_vec++;
    if (q !== 512'h7 || r !== '0 || c !== 514) begin
      n_bad++;
      $display("FAIL back_to_back: q=%h r=%h cycle=%0d required q=7 r=0 cycle 514", q, r, c);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 512'hF0F0;
    bus.divisor = 256'h7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (199) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.quotient !== '0 ||
        bus.remainder !== '0 || dut.state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_mid: busy/done/err=%b%b%b q=%h r=%h state=%0d required zeros, IDLE",
               bus.busy, bus.done, bus.err, bus.quotient, bus.remainder, dut.state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start_ignored();
    int c;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 512'hB;
    bus.divisor = 256'h3;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (bus.done !== 1'b1 && c < 600) begin
      if (c == 10) begin
        bus.start = 1'b1;
        bus.dividend = 512'h9;
        bus.divisor = 256'h5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    n_vec++;
    if (bus.quotient !== 512'h6 || bus.remainder !== 256'h1 || c !== 514) begin
      n_bad++;
      $display("FAIL start_while_busy: q=%h r=%h cycle=%0d required q=6 r=1 cycle 514",
               bus.quotient, bus.remainder, c);
    end
  endtask

  task automatic test_round_trip();
    logic [255:0] a, b, x, mask;
    logic [DW-1:0] cprod, q;
    logic [VW-1:0] r;
    logic e, b1, bd;
    int c;
    for (int k = 0; k < 8; k++) begin
      a = rand256();
      b = rand256();
      if (k == 0) b = 256'h1_0000_0001;
      if (b == '0) b = 256'h3;
      cprod = clmul(a, b);
      run_div(cprod, b, q, r, e, c, b1, bd);
      n_vec++;
      if (q !== {256'b0, a} || r !== '0 || e !== 1'b0) begin
        n_bad++;
        $display("FAIL round_trip_%0d: q=%h r=%h required q=%h r=0", k, q, r, a);
      end
      mask = (256'h1 << deg256(b)) - 256'h1;
      x = rand256() & mask;
      run_div(cprod ^ {256'b0, x}, b, q, r, e, c, b1, bd);
      n_vec++;
      if (q !== {256'b0, a} || r !== x) begin
        n_bad++;
        $display("FAIL round_trip_rem_%0d: q=%h r=%h required q=%h r=%h", k, q, r, a, x);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_small();
    test_top_bits();
    test_zero_divisor();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
